// File: rtl/bru_reg_read_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : bru_reg_read_stage_if
// Purpose  : Bundles the BRU register-read stage signals: IQ issue,
//            WB forward bus, PRF read responses and the execute handoff.
//            slave  = the register-read stage's view
//            master = the environment's view (IQ / PRF / WB / execute)
// Signals  : issue_*        IQ -> stage, one op per cycle
//            pipeline_ready stage -> IQ, stage can accept issue this cycle
//            forward_data_by_bank  WB forward data, valid for one cycle
//            PRF_resp_A/B_* PRF read data for a pending operand
//            exec_*         stage -> execute, valid/ready output register
// Revision : 1.0  initial release
// ============================================================================
interface bru_reg_read_stage_if #(
  parameter int PRF_BANK_COUNT     = 4,
  parameter int LOG_PRF_BANK_COUNT = 2,
  parameter int LOG_PR_COUNT       = 7,
  parameter int LOG_ROB_ENTRIES    = 6
);
  logic                          issue_valid;
  logic [3:0]                    issue_op;
  logic [31:0]                   issue_PC;
  logic [31:0]                   issue_speculated_next_PC;
  logic [31:0]                   issue_imm;
  logic                          issue_A_unneeded;
  logic                          issue_A_forward;
  logic [LOG_PRF_BANK_COUNT-1:0] issue_A_bank;
  logic                          issue_B_unneeded;
  logic                          issue_B_forward;
  logic [LOG_PRF_BANK_COUNT-1:0] issue_B_bank;
  logic [LOG_PR_COUNT-1:0]       issue_dest_PR;
  logic [LOG_ROB_ENTRIES-1:0]    issue_ROB_index;
  logic                          pipeline_ready;

  logic [PRF_BANK_COUNT-1:0][31:0] forward_data_by_bank;

  logic                          PRF_resp_A_valid;
  logic [31:0]                   PRF_resp_A_data;
  logic                          PRF_resp_B_valid;
  logic [31:0]                   PRF_resp_B_data;

  logic                          exec_valid;
  logic                          exec_ready;
  logic [3:0]                    exec_op;
  logic [31:0]                   exec_PC;
  logic [31:0]                   exec_speculated_next_PC;
  logic [31:0]                   exec_imm;
  logic [31:0]                   exec_A_data;
  logic [31:0]                   exec_B_data;
  logic [LOG_PR_COUNT-1:0]       exec_dest_PR;
  logic [LOG_ROB_ENTRIES-1:0]    exec_ROB_index;

  modport slave (
    input  issue_valid, issue_op, issue_PC, issue_speculated_next_PC, issue_imm,
    input  issue_A_unneeded, issue_A_forward, issue_A_bank,
    input  issue_B_unneeded, issue_B_forward, issue_B_bank,
    input  issue_dest_PR, issue_ROB_index,
    output pipeline_ready,
    input  forward_data_by_bank,
    input  PRF_resp_A_valid, PRF_resp_A_data, PRF_resp_B_valid, PRF_resp_B_data,
    output exec_valid,
    input  exec_ready,
    output exec_op, exec_PC, exec_speculated_next_PC, exec_imm,
    output exec_A_data, exec_B_data, exec_dest_PR, exec_ROB_index
  );

  modport master (
    output issue_valid, issue_op, issue_PC, issue_speculated_next_PC, issue_imm,
    output issue_A_unneeded, issue_A_forward, issue_A_bank,
    output issue_B_unneeded, issue_B_forward, issue_B_bank,
    output issue_dest_PR, issue_ROB_index,
    input  pipeline_ready,
    output forward_data_by_bank,
    output PRF_resp_A_valid, PRF_resp_A_data, PRF_resp_B_valid, PRF_resp_B_data,
    input  exec_valid,
    output exec_ready,
    input  exec_op, exec_PC, exec_speculated_next_PC, exec_imm,
    input  exec_A_data, exec_B_data, exec_dest_PR, exec_ROB_index
  );
endinterface
`default_nettype wire

// File: rtl/bru_reg_read_stage.sv
`default_nettype none
// ============================================================================
// Module   : bru_reg_read_stage
// Purpose  : First stage of the BRU pipeline. Accepts one issued op into a
//            single register-read slot, collects operands A/B (forward bus,
//            PRF response, or zero), and hands the op to execute through a
//            valid/ready output register.
// Ports    : CLK, RST   clock, synchronous active-high reset
//            rr         bru_reg_read_stage_if.slave (issue, forward, PRF, exec)
//            perf_operand_stall_count, perf_exec_stall_count
//                       (only when BRU_RR_PERF_COUNT_EN is defined)
// Options  : BRU_RR_PERF_COUNT_EN adds two free-running stall counters.
// Revision : 1.0  initial release
// ============================================================================
module bru_reg_read_stage #(
  parameter int PRF_BANK_COUNT     = 4,
  parameter int LOG_PRF_BANK_COUNT = 2,
  parameter int LOG_PR_COUNT       = 7,
  parameter int LOG_ROB_ENTRIES    = 6
) (
  input  logic CLK,
  input  logic RST,
  bru_reg_read_stage_if.slave rr
`ifdef BRU_RR_PERF_COUNT_EN
  ,
  output logic [31:0] perf_operand_stall_count,
  output logic [31:0] perf_exec_stall_count
`endif
);

  typedef enum logic [0:0] {SLOT_EMPTY = 1'b0, SLOT_COLLECT = 1'b1} slot_state_e;
  // DONE: value held in the slot; FWD: take the forward bus this cycle only;
  // PEND: wait for the PRF response.
  typedef enum logic [1:0] {OPND_DONE = 2'd0, OPND_FWD = 2'd1, OPND_PEND = 2'd2} opnd_state_e;

  slot_state_e                   state_q, state_d;
  opnd_state_e                   a_state_q, a_state_d, b_state_q, b_state_d;
  logic [31:0]                   a_data_q, a_data_d, b_data_q, b_data_d;
  logic [LOG_PRF_BANK_COUNT-1:0] a_bank_q, a_bank_d, b_bank_q, b_bank_d;
  logic [3:0]                    op_q, op_d;
  logic [31:0]                   pc_q, pc_d, npc_q, npc_d, imm_q, imm_d;
  logic [LOG_PR_COUNT-1:0]       dest_q, dest_d;
  logic [LOG_ROB_ENTRIES-1:0]    rob_q, rob_d;

  logic                          exec_valid_q;
  logic [3:0]                    exec_op_q;
  logic [31:0]                   exec_pc_q, exec_npc_q, exec_imm_q, exec_a_q, exec_b_q;
  logic [LOG_PR_COUNT-1:0]       exec_dest_q;
  logic [LOG_ROB_ENTRIES-1:0]    exec_rob_q;

  logic [PRF_BANK_COUNT-1:0][31:0] fwd_bus;
  logic        collecting, a_done, b_done, transfer, ready, load;
  logic [31:0] a_value, b_value;

  function automatic opnd_state_e load_state(input logic unneeded, input logic forward);
    if (unneeded) return OPND_DONE;
    if (forward)  return OPND_FWD;
    return OPND_PEND;
  endfunction

  assign fwd_bus    = rr.forward_data_by_bank;
  assign collecting = (state_q == SLOT_COLLECT);

  // Resolve each operand's value for this cycle; fresh forward/PRF data
  // bypasses straight into the output register on a transfer.
  always_comb begin
    a_value = a_data_q;
    a_done  = 1'b0;
    case (a_state_q)
      OPND_DONE: a_done = 1'b1;
      OPND_FWD:  begin a_done = 1'b1; a_value = fwd_bus[a_bank_q]; end
      OPND_PEND: begin a_done = rr.PRF_resp_A_valid; a_value = rr.PRF_resp_A_data; end
      default:   a_done = 1'b0;
    endcase
    a_done = a_done & collecting;

    b_value = b_data_q;
    b_done  = 1'b0;
    case (b_state_q)
      OPND_DONE: b_done = 1'b1;
      OPND_FWD:  begin b_done = 1'b1; b_value = fwd_bus[b_bank_q]; end
      OPND_PEND: begin b_done = rr.PRF_resp_B_valid; b_value = rr.PRF_resp_B_data; end
      default:   b_done = 1'b0;
    endcase
    b_done = b_done & collecting;
  end

  assign transfer = a_done & b_done & (~exec_valid_q | rr.exec_ready);
  assign ready    = (state_q == SLOT_EMPTY) | transfer;
  assign load     = rr.issue_valid & ready;

  always_comb begin
    state_d   = state_q;
    a_state_d = a_state_q;
    b_state_d = b_state_q;
    a_data_d  = a_data_q;
    b_data_d  = b_data_q;
    a_bank_d  = a_bank_q;
    b_bank_d  = b_bank_q;
    op_d      = op_q;
    pc_d      = pc_q;
    npc_d     = npc_q;
    imm_d     = imm_q;
    dest_d    = dest_q;
    rob_d     = rob_q;
    if (load) begin
      state_d   = SLOT_COLLECT;
      a_state_d = load_state(rr.issue_A_unneeded, rr.issue_A_forward);
      b_state_d = load_state(rr.issue_B_unneeded, rr.issue_B_forward);
      a_data_d  = '0;
      b_data_d  = '0;
      a_bank_d  = rr.issue_A_bank;
      b_bank_d  = rr.issue_B_bank;
      op_d      = rr.issue_op;
      pc_d      = rr.issue_PC;
      npc_d     = rr.issue_speculated_next_PC;
      imm_d     = rr.issue_imm;
      dest_d    = rr.issue_dest_PR;
      rob_d     = rr.issue_ROB_index;
    end else if (transfer) begin
      state_d = SLOT_EMPTY;
    end else if (collecting) begin
      // Forward data exists only in the first collect cycle, so any operand
      // that just completed is captured now.
      if (a_done && a_state_q != OPND_DONE) begin
        a_state_d = OPND_DONE;
        a_data_d  = a_value;
      end
      if (b_done && b_state_q != OPND_DONE) begin
        b_state_d = OPND_DONE;
        b_data_d  = b_value;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= SLOT_EMPTY;
      a_state_q <= OPND_DONE;
      b_state_q <= OPND_DONE;
    end else begin
      state_q   <= state_d;
      a_state_q <= a_state_d;
      b_state_q <= b_state_d;
    end
  end

  // Payload is only consumed after a load, so it needs no reset.
  always_ff @(posedge CLK) begin
    a_data_q <= a_data_d;
    b_data_q <= b_data_d;
    a_bank_q <= a_bank_d;
    b_bank_q <= b_bank_d;
    op_q     <= op_d;
    pc_q     <= pc_d;
    npc_q    <= npc_d;
    imm_q    <= imm_d;
    dest_q   <= dest_d;
    rob_q    <= rob_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      exec_valid_q <= 1'b0;
      exec_op_q    <= '0;
      exec_pc_q    <= '0;
      exec_npc_q   <= '0;
      exec_imm_q   <= '0;
      exec_a_q     <= '0;
      exec_b_q     <= '0;
      exec_dest_q  <= '0;
      exec_rob_q   <= '0;
    end else if (transfer) begin
      exec_valid_q <= 1'b1;
      exec_op_q    <= op_q;
      exec_pc_q    <= pc_q;
      exec_npc_q   <= npc_q;
      exec_imm_q   <= imm_q;
      exec_a_q     <= a_value;
      exec_b_q     <= b_value;
      exec_dest_q  <= dest_q;
      exec_rob_q   <= rob_q;
    end else if (rr.exec_ready) begin
      exec_valid_q <= 1'b0;
    end
  end

  assign rr.pipeline_ready          = ready;
  assign rr.exec_valid              = exec_valid_q;
  assign rr.exec_op                 = exec_op_q;
  assign rr.exec_PC                 = exec_pc_q;
  assign rr.exec_speculated_next_PC = exec_npc_q;
  assign rr.exec_imm                = exec_imm_q;
  assign rr.exec_A_data             = exec_a_q;
  assign rr.exec_B_data             = exec_b_q;
  assign rr.exec_dest_PR            = exec_dest_q;
  assign rr.exec_ROB_index          = exec_rob_q;

`ifdef BRU_RR_PERF_COUNT_EN
  logic [31:0] perf_opnd_q, perf_exec_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_opnd_q <= '0;
      perf_exec_q <= '0;
    end else begin
      if (collecting && !(a_done && b_done)) perf_opnd_q <= perf_opnd_q + 32'd1;
      if (exec_valid_q && !rr.exec_ready)    perf_exec_q <= perf_exec_q + 32'd1;
    end
  end

  assign perf_operand_stall_count = perf_opnd_q;
  assign perf_exec_stall_count    = perf_exec_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bru_reg_read_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_bru_reg_read_stage
// Purpose  : Randomized scoreboard bench for bru_reg_read_stage plus directed
//            latency, throughput, back-pressure and reset scenarios.
// Revision : 1.0  initial release
// ============================================================================
module tb_bru_reg_read_stage;
  localparam int NB = 4, LB = 2, LPR = 7, LROB = 6;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  bru_reg_read_stage_if #(.PRF_BANK_COUNT(NB), .LOG_PRF_BANK_COUNT(LB),
                          .LOG_PR_COUNT(LPR), .LOG_ROB_ENTRIES(LROB)) rr();

`ifdef BRU_RR_PERF_COUNT_EN
  logic [31:0] perf_op, perf_ex, p_snap;
`endif

  bru_reg_read_stage #(.PRF_BANK_COUNT(NB), .LOG_PRF_BANK_COUNT(LB),
                       .LOG_PR_COUNT(LPR), .LOG_ROB_ENTRIES(LROB)) dut (
    .CLK(CLK),
    .RST(RST),
    .rr(rr)
`ifdef BRU_RR_PERF_COUNT_EN
    ,
    .perf_operand_stall_count(perf_op),
    .perf_exec_stall_count(perf_ex)
`endif
  );

  typedef struct packed {
    logic [3:0]      op;
    logic [31:0]     pc, npc, imm, a, b;
    logic [LPR-1:0]  dest;
    logic [LROB-1:0] rob;
  } exp_t;

  // kind: 0 unneeded, 1 forward, 2 PRF
  typedef struct {
    logic [3:0]      op;
    logic [31:0]     pc, npc, imm;
    logic [LPR-1:0]  dest;
    logic [LROB-1:0] rob;
    int              a_kind, b_kind;
    logic [LB-1:0]   a_bank, b_bank;
    logic [31:0]     a_val, b_val;
    int              a_dly, b_dly;
  } txn_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Environment state owned by the driver process.
  int            cyc = 0;
  bit            pA = 0, pB = 0, fA_now = 0, fB_now = 0;
  int            a_at = 0, b_at = 0;
  logic [31:0]   a_val = 0, b_val = 0, fA_val = 0, fB_val = 0;
  logic [LB-1:0] fA_bank = 0, fB_bank = 0;

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endfunction

  // Scoreboard monitor: every cycle exec_valid is high the outputs must match
  // the oldest expected op; it retires on the handshake.
  exp_t got_m;
  always @(negedge CLK) begin
    if (!RST && rr.exec_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_exec_valid", 64'd1, 64'd0);
      end else begin
        got_m.op   = rr.exec_op;
        got_m.pc   = rr.exec_PC;
        got_m.npc  = rr.exec_speculated_next_PC;
        got_m.imm  = rr.exec_imm;
        got_m.a    = rr.exec_A_data;
        got_m.b    = rr.exec_B_data;
        got_m.dest = rr.exec_dest_PR;
        got_m.rob  = rr.exec_ROB_index;
        n_checks++;
        if (got_m === sb[0]) n_pass++;
        else $display("FAIL exec_txn: got op=%h pc=%h npc=%h imm=%h A=%h B=%h dest=%h rob=%h expected op=%h pc=%h npc=%h imm=%h A=%h B=%h dest=%h rob=%h",
                      got_m.op, got_m.pc, got_m.npc, got_m.imm, got_m.a, got_m.b, got_m.dest, got_m.rob,
                      sb[0].op, sb[0].pc, sb[0].npc, sb[0].imm, sb[0].a, sb[0].b, sb[0].dest, sb[0].rob);
        if (rr.exec_ready) void'(sb.pop_front());
      end
    end
  end

  function automatic txn_t rand_txn(input int max_kind);
    txn_t t;
    t.op     = 4'($urandom);
    t.pc     = $urandom;
    t.npc    = $urandom;
    t.imm    = $urandom;
    t.dest   = LPR'($urandom);
    t.rob    = LROB'($urandom);
    t.a_kind = int'($urandom_range(max_kind));
    t.b_kind = int'($urandom_range(max_kind));
    t.a_bank = LB'($urandom);
    t.b_bank = LB'($urandom);
    t.a_val  = $urandom;
    t.b_val  = $urandom;
    t.a_dly  = int'($urandom_range(4, 1));
    t.b_dly  = int'($urandom_range(4, 1));
    return t;
  endfunction

  // Start a cycle: drive the forward bus, PRF responses and exec_ready,
  // then leave time for pipeline_ready to settle.
  task automatic cycle_begin(input bit rdy);
    @(posedge CLK);
    #1;
    cyc++;
    rr.issue_valid = 1'b0;
    rr.exec_ready  = rdy;
    for (int k = 0; k < NB; k++) rr.forward_data_by_bank[k] = $urandom;
    if (fA_now) rr.forward_data_by_bank[fA_bank] = fA_val;
    if (fB_now) rr.forward_data_by_bank[fB_bank] = fB_val;
    fA_now = 0;
    fB_now = 0;
    if (pA && cyc >= a_at) begin
      rr.PRF_resp_A_valid = 1'b1; rr.PRF_resp_A_data = a_val; pA = 0;
    end else begin
      rr.PRF_resp_A_valid = !pA && ($urandom_range(3) == 0); rr.PRF_resp_A_data = $urandom;
    end
    if (pB && cyc >= b_at) begin
      rr.PRF_resp_B_valid = 1'b1; rr.PRF_resp_B_data = b_val; pB = 0;
    end else begin
      rr.PRF_resp_B_valid = !pB && ($urandom_range(3) == 0); rr.PRF_resp_B_data = $urandom;
    end
    #1;
  endtask

  // Issue one op this cycle and record what execute must eventually see.
  task automatic do_issue(input txn_t t);
    exp_t e;
    rr.issue_valid              = 1'b1;
    rr.issue_op                 = t.op;
    rr.issue_PC                 = t.pc;
    rr.issue_speculated_next_PC = t.npc;
    rr.issue_imm                = t.imm;
    rr.issue_dest_PR            = t.dest;
    rr.issue_ROB_index          = t.rob;
    rr.issue_A_unneeded         = (t.a_kind == 0);
    rr.issue_A_forward          = (t.a_kind == 1);
    rr.issue_A_bank             = t.a_bank;
    rr.issue_B_unneeded         = (t.b_kind == 0);
    rr.issue_B_forward          = (t.b_kind == 1);
    rr.issue_B_bank             = t.b_bank;
    e.op = t.op; e.pc = t.pc; e.npc = t.npc; e.imm = t.imm; e.dest = t.dest; e.rob = t.rob;
    e.a = (t.a_kind == 0) ? 32'h0 : t.a_val;
    if (t.b_kind == 0) e.b = 32'h0;
    else if (t.b_kind == 1 && t.a_kind == 1 && t.a_bank == t.b_bank) e.b = t.a_val;
    else e.b = t.b_val;
    if (t.a_kind == 1) begin fA_now = 1; fA_bank = t.a_bank; fA_val = t.a_val; end
    if (t.a_kind == 2) begin pA = 1; a_at = cyc + t.a_dly; a_val = t.a_val; end
    if (t.b_kind == 1) begin fB_now = 1; fB_bank = t.b_bank; fB_val = e.b; end
    if (t.b_kind == 2) begin pB = 1; b_at = cyc + t.b_dly; b_val = t.b_val; end
    sb.push_back(e);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      cycle_begin(1'b1);
      @(negedge CLK);
      #1;
      n++;
    end
    chk(nm, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    int   issued;
    rr.issue_valid = 0; rr.issue_op = 0; rr.issue_PC = 0; rr.issue_speculated_next_PC = 0;
    rr.issue_imm = 0; rr.issue_A_unneeded = 0; rr.issue_A_forward = 0; rr.issue_A_bank = 0;
    rr.issue_B_unneeded = 0; rr.issue_B_forward = 0; rr.issue_B_bank = 0;
    rr.issue_dest_PR = 0; rr.issue_ROB_index = 0; rr.forward_data_by_bank = '0;
    rr.PRF_resp_A_valid = 0; rr.PRF_resp_A_data = 0; rr.PRF_resp_B_valid = 0;
    rr.PRF_resp_B_data = 0; rr.exec_ready = 1;

    // Reset state
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("reset_pipeline_ready", 64'(rr.pipeline_ready), 64'd1);
    chk("reset_exec_valid", 64'(rr.exec_valid), 64'd0);
    chk("reset_exec_A", 64'(rr.exec_A_data), 64'd0);
    chk("reset_exec_PC", 64'(rr.exec_PC), 64'd0);
`ifdef BRU_RR_PERF_COUNT_EN
    chk("reset_perf_op", 64'(perf_op), 64'd0);
    chk("reset_perf_ex", 64'(perf_ex), 64'd0);
`endif

    // Randomized traffic with random back-pressure
    issued = 0;
    for (int c = 0; c < 4000 && issued < 300; c++) begin
      cycle_begin($urandom_range(3) != 0);
      if (rr.pipeline_ready && $urandom_range(3) != 0) begin
        do_issue(rand_txn(2));
        issued++;
      end
    end
    chk("random_issue_count", 64'(issued), 64'd300);
    drain("drain_random");

    // Forward A from bank 2, B unneeded: exec_valid two cycles after issue
    cycle_begin(1'b1);
    chk("t1_ready", 64'(rr.pipeline_ready), 64'd1);
    t = rand_txn(2);
    t.a_kind = 1; t.a_bank = 2; t.a_val = 32'h1234; t.b_kind = 0;
    do_issue(t);
    cycle_begin(1'b1);
    @(negedge CLK);
    chk("t1_valid_t+1", 64'(rr.exec_valid), 64'd0);
    cycle_begin(1'b1);
    @(negedge CLK);
    chk("t1_valid_t+2", 64'(rr.exec_valid), 64'd1);
    chk("t1_A", 64'(rr.exec_A_data), 64'h1234);
    chk("t1_B", 64'(rr.exec_B_data), 64'h0);
    drain("drain_t1");

    // Both PRF: A at t+1, B at t+4
`ifdef BRU_RR_PERF_COUNT_EN
    p_snap = perf_op;
`endif
    cycle_begin(1'b1);
    t = rand_txn(2);
    t.a_kind = 2; t.b_kind = 2; t.a_dly = 1; t.b_dly = 4;
    do_issue(t);
    for (int i = 1; i <= 4; i++) begin
      cycle_begin(1'b1);
      @(negedge CLK);
      chk($sformatf("t2_ready_t+%0d", i), 64'(rr.pipeline_ready), (i == 4) ? 64'd1 : 64'd0);
    end
    cycle_begin(1'b1);
    @(negedge CLK);
    chk("t2_valid_t+5", 64'(rr.exec_valid), 64'd1);
`ifdef BRU_RR_PERF_COUNT_EN
    chk("t2_perf_operand_stall", 64'(perf_op - p_snap), 64'd3);
`endif
    drain("drain_t2");

    // Back-to-back forward/unneeded ops at full rate
    for (int i = 0; i < 8; i++) begin
      cycle_begin(1'b1);
      if (i < 6) begin
        chk($sformatf("t3_ready_%0d", i), 64'(rr.pipeline_ready), 64'd1);
        do_issue(rand_txn(1));
      end
      @(negedge CLK);
      chk($sformatf("t3_valid_%0d", i), 64'(rr.exec_valid), (i >= 2) ? 64'd1 : 64'd0);
    end
    drain("drain_t3");

    // Execute back-pressure for three cycles with a second op waiting
`ifdef BRU_RR_PERF_COUNT_EN
    p_snap = perf_ex;
`endif
    cycle_begin(1'b1);
    t = rand_txn(1);
    do_issue(t);
    cycle_begin(1'b1);
    chk("t4_ready_t+1", 64'(rr.pipeline_ready), 64'd1);
    t = rand_txn(1);
    do_issue(t);
    for (int i = 2; i <= 4; i++) begin
      cycle_begin(1'b0);
      @(negedge CLK);
      chk($sformatf("t4_ready_t+%0d", i), 64'(rr.pipeline_ready), 64'd0);
      chk($sformatf("t4_valid_t+%0d", i), 64'(rr.exec_valid), 64'd1);
    end
    cycle_begin(1'b1);
    @(negedge CLK);
    chk("t4_ready_t+5", 64'(rr.pipeline_ready), 64'd1);
`ifdef BRU_RR_PERF_COUNT_EN
    chk("t4_perf_exec_stall", 64'(perf_ex - p_snap), 64'd3);
`endif
    drain("drain_t4");

    // Reset while B is pending; its response arrives after reset
    cycle_begin(1'b1);
    t = rand_txn(2);
    t.a_kind = 0; t.b_kind = 2; t.b_dly = 2;
    do_issue(t);
    cycle_begin(1'b1);
    RST = 1'b1;
    cycle_begin(1'b1);
    RST = 1'b0;
    void'(sb.pop_back());
    chk("t5_resp_driven", 64'(rr.PRF_resp_B_valid), 64'd1);
    @(negedge CLK);
    chk("t5_ready", 64'(rr.pipeline_ready), 64'd1);
    chk("t5_valid", 64'(rr.exec_valid), 64'd0);
    chk("t5_exec_op", 64'(rr.exec_op), 64'd0);
    chk("t5_exec_B", 64'(rr.exec_B_data), 64'd0);
`ifdef BRU_RR_PERF_COUNT_EN
    chk("t5_perf_op", 64'(perf_op), 64'd0);
    chk("t5_perf_ex", 64'(perf_ex), 64'd0);
`endif
    for (int i = 0; i < 4; i++) begin
      cycle_begin(1'b1);
      @(negedge CLK);
      chk($sformatf("t5_valid_after_%0d", i), 64'(rr.exec_valid), 64'd0);
    end

    // A final op after reset still flows normally
    cycle_begin(1'b1);
    do_issue(rand_txn(2));
    drain("drain_final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
